// File: rtl/drive_sequencer.sv
// Motion sequencer for the PWM driver: turns host commands into ZF/SP/EN with
// enforced dead-time before stop/reversal, a slow-speed ramp, and obstacle override.
module drive_sequencer #(
    parameter int DEAD_CYC = 50,
    parameter int RAMP_CYC = 200
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [1:0] host_cmd,
    input  logic       host_fast,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       obst,
    output logic       ZF,
    output logic       SP,
    output logic       EN,
    output logic       obst_flag,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_DEAD = 2'd1,
        ST_SLOW = 2'd2,
        ST_FAST = 2'd3
    } state_t;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYC - 1);
    localparam logic [15:0] RAMP_LAST = 16'(RAMP_CYC - 1);

    state_t      state_reg;
    logic [15:0] cnt_reg;
    logic        obst_meta_reg;
    logic        obst_s_reg;
    logic        tgt_run_reg;
    logic        tgt_dir_reg;
    logic        tgt_fast_reg;

    logic        accept;
    logic        cmd_run;
    logic        must_stop;
    logic        can_start;

    // Commands are refused during dead time and while the obstacle is seen.
    assign host_ready = (state_reg != ST_DEAD) && !obst_s_reg;
    assign accept     = host_valid && host_ready;
    assign cmd_run    = (host_cmd == 2'b01) || (host_cmd == 2'b10);
    assign must_stop  = obst_s_reg || !tgt_run_reg || (tgt_dir_reg != ZF);
    assign can_start  = tgt_run_reg && !obst_s_reg;
    assign state      = state_reg;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            obst_meta_reg <= 1'b0;
            obst_s_reg    <= 1'b0;
        end else begin
            obst_meta_reg <= obst;
            obst_s_reg    <= obst_meta_reg;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            tgt_run_reg  <= 1'b0;
            tgt_dir_reg  <= 1'b1;
            tgt_fast_reg <= 1'b0;
            obst_flag    <= 1'b0;
        end else begin
            if (obst_s_reg) begin
                tgt_run_reg <= 1'b0;
            end else if (accept) begin
                tgt_run_reg <= cmd_run;
                if (cmd_run) begin
                    tgt_dir_reg <= (host_cmd == 2'b01);
                end
            end
            if (accept) begin
                tgt_fast_reg <= host_fast;
            end
            // Set has priority over the clear-on-accept.
            if (obst_s_reg) begin
                obst_flag <= 1'b1;
            end else if (accept) begin
                obst_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_STOP;
            cnt_reg   <= 16'd0;
            ZF        <= 1'b1;
            SP        <= 1'b0;
            EN        <= 1'b0;
        end else begin
            case (state_reg)
                ST_STOP: begin
                    if (can_start) begin
                        state_reg <= ST_SLOW;
                        cnt_reg   <= 16'd0;
                        ZF        <= tgt_dir_reg;
                        EN        <= 1'b1;
                        SP        <= 1'b0;
                    end
                end
                ST_DEAD: begin
                    if (cnt_reg == DEAD_LAST) begin
                        cnt_reg <= 16'd0;
                        if (can_start) begin
                            state_reg <= ST_SLOW;
                            ZF        <= tgt_dir_reg;
                            EN        <= 1'b1;
                        end else begin
                            state_reg <= ST_STOP;
                            EN        <= 1'b0;
                        end
                        SP <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_SLOW: begin
                    if (must_stop) begin
                        state_reg <= ST_DEAD;
                        cnt_reg   <= 16'd0;
                        EN        <= 1'b0;
                        SP        <= 1'b0;
                    end else if ((cnt_reg == RAMP_LAST) && tgt_fast_reg) begin
                        state_reg <= ST_FAST;
                        cnt_reg   <= 16'd0;
                        SP        <= 1'b1;
                    end else if (cnt_reg != RAMP_LAST) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                ST_FAST: begin
                    if (must_stop) begin
                        state_reg <= ST_DEAD;
                        cnt_reg   <= 16'd0;
                        EN        <= 1'b0;
                        SP        <= 1'b0;
                    end else if (!tgt_fast_reg) begin
                        // Speed-only downgrade keeps EN and ZF; ramp restarts.
                        state_reg <= ST_SLOW;
                        cnt_reg   <= 16'd0;
                        SP        <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_STOP;
                    cnt_reg   <= 16'd0;
                    EN        <= 1'b0;
                    SP        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with DEAD_CYC=4, RAMP_CYC=8.
module tb_drive_sequencer;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic [1:0] host_cmd;
    logic       host_fast;
    logic       host_valid;
    logic       host_ready;
    logic       obst;
    logic       ZF;
    logic       SP;
    logic       EN;
    logic       obst_flag;
    logic [1:0] state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk1 = ~clk1;

    drive_sequencer #(
        .DEAD_CYC(4),
        .RAMP_CYC(8)
    ) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .host_cmd  (host_cmd),
        .host_fast (host_fast),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .obst      (obst),
        .ZF        (ZF),
        .SP        (SP),
        .EN        (EN),
        .obst_flag (obst_flag),
        .state     (state)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [1:0] cmd, input logic fast);
        host_cmd   = cmd;
        host_fast  = fast;
        host_valid = 1'b1;
        total_cnt++;
        if (host_ready !== 1'b1) $display("FAIL send_ready cmd=%b: host_ready=%b required 1", cmd, host_ready);
        else pass_cnt++;
        tick();
        host_valid = 1'b0;
        $display("send cmd=%b fast=%b -> state=%0d EN=%b SP=%b ZF=%b", cmd, fast, state, EN, SP, ZF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; host_cmd = 2'b00; host_fast = 1'b0; host_valid = 1'b0; obst = 1'b0;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF, host_ready, obst_flag} !== 7'b00_0_0_1_1_0)
            $display("FAIL reset_hold: {state,EN,SP,ZF,rdy,flag}=%b required 0000110", {state, EN, SP, ZF, host_ready, obst_flag});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF, host_ready} !== 6'b00_0_0_1_1)
            $display("FAIL reset_release: {state,EN,SP,ZF,rdy}=%b required 000011", {state, EN, SP, ZF, host_ready});
        else pass_cnt++;
        $display("reset done state=%0d host_ready=%b", state, host_ready);
    endtask

    task automatic test_forward_fast();
        send(2'b01, 1'b1);
        total_cnt++;
        if ({state, EN} !== 3'b00_0) $display("FAIL fwd_edge0: {state,EN}=%b required 000", {state, EN});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL fwd_edge1: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        repeat (7) tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL fwd_edge8: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b11_1_1_1) $display("FAIL fwd_edge9: {state,EN,SP,ZF}=%b required 11111", {state, EN, SP, ZF});
        else pass_cnt++;
    endtask

    task automatic test_reverse();
        send(2'b10, 1'b1);
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b11_1_1_1) $display("FAIL rev_edgeN: {state,EN,SP,ZF}=%b required 11111", {state, EN, SP, ZF});
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total_cnt++;
            if ({state, EN, SP, ZF, host_ready} !== 6'b01_0_0_1_0)
                $display("FAIL rev_dead_%0d: {state,EN,SP,ZF,rdy}=%b required 010010", k, {state, EN, SP, ZF, host_ready});
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF, host_ready} !== 6'b10_1_0_0_1)
            $display("FAIL rev_restart: {state,EN,SP,ZF,rdy}=%b required 101001", {state, EN, SP, ZF, host_ready});
        else pass_cnt++;
        $display("reverse done state=%0d ZF=%b", state, ZF);
    endtask

    task automatic test_obstacle();
        obst = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({state, EN, host_ready, obst_flag} !== 5'b10_1_0_0)
            $display("FAIL obst_k1: {state,EN,rdy,flag}=%b required 10100", {state, EN, host_ready, obst_flag});
        else pass_cnt++;
        tick();
        obst = 1'b0;
        total_cnt++;
        if ({state, EN, host_ready, obst_flag} !== 5'b01_0_0_1)
            $display("FAIL obst_k2: {state,EN,rdy,flag}=%b required 01001", {state, EN, host_ready, obst_flag});
        else pass_cnt++;
        repeat (3) tick();
        total_cnt++;
        if ({state, EN} !== 3'b01_0) $display("FAIL obst_k5: {state,EN}=%b required 010", {state, EN});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({state, EN, host_ready, obst_flag} !== 5'b00_0_1_1)
            $display("FAIL obst_k6: {state,EN,rdy,flag}=%b required 00011", {state, EN, host_ready, obst_flag});
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if ({state, EN, obst_flag} !== 4'b00_0_1) $display("FAIL obst_no_resume: {state,EN,flag}=%b required 0001", {state, EN, obst_flag});
        else pass_cnt++;
        $display("obstacle done state=%0d obst_flag=%b", state, obst_flag);
    endtask

    task automatic test_speed_only();
        send(2'b01, 1'b1);
        total_cnt++;
        if ({state, obst_flag} !== 3'b00_0) $display("FAIL speed_flag_clear: {state,flag}=%b required 000", {state, obst_flag});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL speed_start: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        repeat (8) tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b11_1_1_1) $display("FAIL speed_fast1: {state,EN,SP,ZF}=%b required 11111", {state, EN, SP, ZF});
        else pass_cnt++;
        send(2'b01, 1'b0);
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b11_1_1_1) $display("FAIL speed_cmd_slow: {state,EN,SP,ZF}=%b required 11111", {state, EN, SP, ZF});
        else pass_cnt++;
        send(2'b01, 1'b1);
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL speed_down: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total_cnt++;
            if ({state, EN, SP, ZF} !== 5'b10_1_0_1)
                $display("FAIL speed_ramp_%0d: {state,EN,SP,ZF}=%b required 10101", i, {state, EN, SP, ZF});
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b11_1_1_1) $display("FAIL speed_fast2: {state,EN,SP,ZF}=%b required 11111", {state, EN, SP, ZF});
        else pass_cnt++;
        $display("speed-only done state=%0d", state);
    endtask

    task automatic test_back_to_back();
        int n;
        send(2'b01, 1'b0);
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL b2b_slow: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        send(2'b00, 1'b0);
        tick();
        total_cnt++;
        if ({state, EN, host_ready} !== 4'b01_0_0) $display("FAIL b2b_dead: {state,EN,rdy}=%b required 0100", {state, EN, host_ready});
        else pass_cnt++;
        n = 0;
        while (!host_ready && n < 20) begin
            tick();
            n++;
        end
        total_cnt++;
        if (n !== 4 || state !== 2'd0) $display("FAIL b2b_wait: cycles=%0d state=%0d required 4 and 0", n, state);
        else pass_cnt++;
        send(2'b01, 1'b0);
        total_cnt++;
        if ({state, EN} !== 3'b00_0) $display("FAIL b2b_accept: {state,EN}=%b required 000", {state, EN});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({state, EN, SP, ZF} !== 5'b10_1_0_1) $display("FAIL b2b_restart: {state,EN,SP,ZF}=%b required 10101", {state, EN, SP, ZF});
        else pass_cnt++;
        $display("back-to-back done wait=%0d state=%0d", n, state);
    endtask

    task automatic test_async_reset();
        int n;
        send(2'b10, 1'b1);
        n = 0;
        while (state !== 2'd3 && n < 30) begin
            tick();
            n++;
        end
        total_cnt++;
        if (state !== 2'd3 || ZF !== 1'b0) $display("FAIL areset_reach_fast: state=%0d ZF=%b required 3 and 0", state, ZF);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({state, EN, SP, ZF, host_ready, obst_flag} !== 7'b00_0_0_1_1_0)
            $display("FAIL areset_async: {state,EN,SP,ZF,rdy,flag}=%b required 0000110", {state, EN, SP, ZF, host_ready, obst_flag});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({state, EN, SP, ZF, host_ready} !== 6'b00_0_0_1_1)
            $display("FAIL areset_after: {state,EN,SP,ZF,rdy}=%b required 000011", {state, EN, SP, ZF, host_ready});
        else pass_cnt++;
        $display("async reset done state=%0d", state);
    endtask

    initial begin
        test_reset();
        test_forward_fast();
        test_reverse();
        test_obstacle();
        test_speed_only();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Motion controller that sequences the motor PWM driver's `ZF` (direction), `SP` (speed) and `EN` (enable) inputs from host commands, with an obstacle-sensor override. It guarantees a dead-time with `EN=0` before any direction reversal or stop-to-restart. It also enforces a slow-speed ramp before full speed. It sits between the car's command logic and the PWM block, in the `clk1` domain.

## Interface

- `DEAD_CYC`, 50, number of `clk1` cycles `EN` is held low on every stop or reversal; legal range 1..65535
- `RAMP_CYC`, 200, minimum number of `clk1` cycles spent at `SP=0` before `SP=1` is allowed; legal range 1..65535

- `clk1`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `host_cmd`  in  2  command code: 00 stop, 01 forward, 10 reverse, 11 treated as stop
- `host_fast`  in  1  requested speed with the command: 1 full, 0 slow
- `host_valid`  in  1  command valid
- `host_ready`  out  1  command accept; a transfer occurs when `host_valid && host_ready` at a rising edge
- `obst`  in  1  asynchronous obstacle sensor, active-high
- `ZF`  out  1  direction to PWM: 1 forward, 0 reverse
- `SP`  out  1  speed to PWM: 1 full, 0 slow (PWM duty)
- `EN`  out  1  motor enable to PWM
- `obst_flag`  out  1  sticky indication that an obstacle stop occurred
- `state`  out  2  current state encoding: STOP=0, DEAD=1, SLOW=2, FAST=3

## Operation

- `obst` passes through a 2-flop synchronizer to produce `obst_s`; both flops reset to 0.
- Target registers `tgt_run`, `tgt_dir` and `tgt_fast` are loaded on every accepted command:
  - cmd 01: run=1, dir=1
  - cmd 10: run=1, dir=0
  - cmd 00 or 11: run=0, dir unchanged
  - fast = `host_fast`
- `host_ready` = (state != DEAD) && !`obst_s`. It is combinational and equals 1 during reset.
- While `obst_s`=1, `tgt_run` is forced to 0 and `obst_flag` is set. `obst_flag` clears on the next accepted command. Set wins if both occur in the same cycle.
- State machine transitions, in priority order within each state:
  - STOP: if `tgt_run` && !`obst_s`, go to SLOW, load `ZF`←`tgt_dir` and clear the counter.
  - DEAD: the counter increments each cycle. At count = `DEAD_CYC`−1, go to SLOW (load `ZF`←`tgt_dir`) if `tgt_run` && !`obst_s`; otherwise go to STOP.
  - SLOW: go to DEAD and clear the counter if `obst_s`, or !`tgt_run`, or `tgt_dir`≠`ZF`. Otherwise the counter increments, saturating at `RAMP_CYC`−1. Go to FAST when count = `RAMP_CYC`−1 and `tgt_fast`=1.
  - FAST: go to DEAD and clear the counter if `obst_s`, or !`tgt_run`, or `tgt_dir`≠`ZF`. Otherwise go to SLOW and clear the counter if `tgt_fast`=0.
- Same-direction commands in SLOW or FAST change only the speed target and never pass through DEAD.
- Output decode is registered and updated with the state:
  - `EN`=1 only in SLOW and FAST
  - `SP`=1 only in FAST
  - `ZF` changes only on the transition into SLOW from STOP or DEAD
- The counter is 16 bits unsigned with no wrap: it is cleared on every state entry and saturates in SLOW.

## Timing

- Reset values: state=STOP, `ZF`=1, `SP`=0, `EN`=0, `obst_flag`=0, counter=0, `tgt_run`=0, `tgt_dir`=1, `tgt_fast`=0, `host_ready`=1.
- Command accepted at edge N: `EN` rises at edge N+1 from STOP. Stop or reverse is visible at edge N+1 as state=DEAD with `EN`=0.
- DEAD entered at edge M: `EN`=0 for exactly `DEAD_CYC` cycles. It exits at edge M+`DEAD_CYC`, and on a restart `EN`=1 with the new `ZF` from that edge.
- SLOW entered at edge S with `tgt_fast`=1: `SP` rises at edge S+`RAMP_CYC`.
- `obst` rising edge sampled at edge K: `obst_s` is high after K+1, and `EN` is low after K+2. `host_ready` is low from K+1 until `obst_s` falls.
- Reset mid-operation forces all outputs low immediately, except `ZF`=1 and `host_ready`=1, regardless of the clock.
- A simultaneous obstacle and accepted command cannot occur because `host_ready`=0 whenever `obst_s`=1.

## Test plan

All scenarios use `DEAD_CYC`=4, `RAMP_CYC`=8.

- **Reset:** assert `rst_n`=0 mid-FAST → `EN`=`SP`=0 and `ZF`=1 asynchronously. After release, state=STOP and `host_ready`=1.
- **Forward fast from STOP:** cmd 01, fast=1, accepted at edge 0 → `EN`=1, `ZF`=1, `SP`=0 at edge 1; `SP`=1 at edge 9.
- **Reverse while FAST:** cmd 10 accepted at edge N → `EN`=0 at edges N+1..N+4 with `host_ready`=0. At N+5: `EN`=1, `ZF`=0, `SP`=0.
- **Obstacle pulse while SLOW:** `obst`=1 for 3 cycles → `EN` falls 2 cycles later and `obst_flag`=1. After dead time the state is STOP with `EN`=0, and the block does not resume without a new command.
- **Speed-only change:** forward fast, then cmd 01 fast=0 → FAST→SLOW with no `EN` drop and `ZF` unchanged. A later cmd 01 fast=1 reaches FAST 8 cycles later.
- **Back-to-back commands:** a stop accepted while SLOW, followed by cmd 01 accepted on the first cycle `host_ready`=1 after DEAD → STOP→SLOW at the next edge with no extra dead time.
